// File: rtl/tdm_demux_4.sv
// tdm_demux_4: 1:4 time-division demultiplexer with sof-based framing.
// Slots 0..2 are held in shadow registers; the slot-3 beat completes the
// frame and all four outputs load together, so a partial frame never
// reaches y1..y4.
module tdm_demux_4 #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    input  logic             sof,
    output logic [WIDTH-1:0] y1,
    output logic [WIDTH-1:0] y2,
    output logic [WIDTH-1:0] y3,
    output logic [WIDTH-1:0] y4,
    output logic             c1,
    output logic             c2,
    output logic             frame_valid,
    output logic             sync_err
);

    typedef enum logic {
        HUNT = 1'b0,
        SYNC = 1'b1
    } state_t;

    state_t           state;
    logic [1:0]       slot;
    logic [WIDTH-1:0] sh0;
    logic [WIDTH-1:0] sh1;
    logic [WIDTH-1:0] sh2;

    // Slot counter is the registered next-slot indication.
    assign c1 = slot[1];
    assign c2 = slot[0];

    // Framing FSM, shadow capture and double-buffered output load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= HUNT;
            slot        <= 2'd0;
            sh0         <= '0;
            sh1         <= '0;
            sh2         <= '0;
            y1          <= '0;
            y2          <= '0;
            y3          <= '0;
            y4          <= '0;
            frame_valid <= 1'b0;
            sync_err    <= 1'b0;
        end else begin
            frame_valid <= 1'b0;
            sync_err    <= 1'b0;
            if (din_valid) begin
                case (state)
                    HUNT: begin
                        if (sof) begin
                            sh0   <= din;
                            slot  <= 2'd1;
                            state <= SYNC;
                        end
                    end
                    SYNC: begin
                        if (slot == 2'd0) begin
                            if (sof) begin
                                sh0  <= din;
                                slot <= 2'd1;
                            end else begin
                                // Missing sof: drop the beat and re-hunt.
                                sync_err <= 1'b1;
                                slot     <= 2'd0;
                                state    <= HUNT;
                            end
                        end else if (sof) begin
                            // Early sof: abandon partial frame, restart at slot 0.
                            sync_err <= 1'b1;
                            sh0      <= din;
                            slot     <= 2'd1;
                        end else begin
                            case (slot)
                                2'd1:    sh1 <= din;
                                2'd2:    sh2 <= din;
                                default: begin
                                    y1          <= sh0;
                                    y2          <= sh1;
                                    y3          <= sh2;
                                    y4          <= din;
                                    frame_valid <= 1'b1;
                                end
                            endcase
                            slot <= slot + 2'd1;
                        end
                    end
                    default: begin
                        state <= HUNT;
                        slot  <= 2'd0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_tdm_demux_4.sv
// tb_tdm_demux_4: directed self-checking bench with a frame scoreboard.
module tb_tdm_demux_4;

    localparam int unsigned W = 1;

    logic         clk;
    logic         rst_n;
    logic [W-1:0] din;
    logic         din_valid;
    logic         sof;
    logic [W-1:0] y1;
    logic [W-1:0] y2;
    logic [W-1:0] y3;
    logic [W-1:0] y4;
    logic         c1;
    logic         c2;
    logic         frame_valid;
    logic         sync_err;

    int unsigned total = 0;
    int unsigned bad   = 0;
    logic [3:0]  exp_q[$];
    logic [3:0]  y_hold;
    logic [3:0]  y_exp;

    tdm_demux_4 #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .din         (din),
        .din_valid   (din_valid),
        .sof         (sof),
        .y1          (y1),
        .y2          (y2),
        .y3          (y3),
        .y4          (y4),
        .c1          (c1),
        .c2          (c2),
        .frame_valid (frame_valid),
        .sync_err    (sync_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] yv();
        return {y1, y2, y3, y4};
    endfunction

    // Async reset pulse between clock edges; outputs must clear with no edge.
    task automatic do_reset();
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("rst_y", 32'(yv()), 32'd0);
        check("rst_c", 32'({c1, c2}), 32'd0);
        check("rst_fv", 32'(frame_valid), 32'd0);
        check("rst_err", 32'(sync_err), 32'd0);
        y_hold = 4'd0;
        #1 rst_n = 1'b1;
    endtask

    // One valid beat, then check pulses, next-slot and outputs after the edge.
    task automatic beat(input string tag, input logic s, input logic [W-1:0] d,
                        input logic efv, input logic eerr, input logic [1:0] ec);
        @(negedge clk);
        din_valid = 1'b1;
        sof       = s;
        din       = d;
        @(posedge clk);
        #1;
        din_valid = 1'b0;
        sof       = 1'b0;
        check({tag, "_fv"}, 32'(frame_valid), 32'(efv));
        check({tag, "_err"}, 32'(sync_err), 32'(eerr));
        check({tag, "_c"}, 32'({c1, c2}), 32'(ec));
        if (frame_valid && exp_q.size() > 0) begin
            y_exp = exp_q.pop_front();
            check({tag, "_frame"}, 32'(yv()), 32'(y_exp));
            y_hold = y_exp;
        end else begin
            check({tag, "_hold"}, 32'(yv()), 32'(y_hold));
        end
    endtask

    // Idle cycles: nothing may change.
    task automatic idle(input int n, input logic [1:0] ec);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            din_valid = 1'b0;
            @(posedge clk);
            #1;
            check("idle_fv", 32'(frame_valid), 32'd0);
            check("idle_err", 32'(sync_err), 32'd0);
            check("idle_c", 32'({c1, c2}), 32'(ec));
            check("idle_y", 32'(yv()), 32'(y_hold));
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        din       = '0;
        din_valid = 1'b0;
        sof       = 1'b0;
        y_hold    = 4'd0;
        #2;
        check("init_y", 32'(yv()), 32'd0);
        check("init_c", 32'({c1, c2}), 32'd0);
        check("init_fv", 32'(frame_valid), 32'd0);
        check("init_err", 32'(sync_err), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic frame 0,1,0,1
        exp_q.push_back(4'b0101);
        beat("f1b0", 1'b1, 1'b0, 1'b0, 1'b0, 2'd1);
        beat("f1b1", 1'b0, 1'b1, 1'b0, 1'b0, 2'd2);
        beat("f1b2", 1'b0, 1'b0, 1'b0, 1'b0, 2'd3);
        beat("f1b3", 1'b0, 1'b1, 1'b1, 1'b0, 2'd0);
        idle(1, 2'd0);

        // Data before sync is ignored
        do_reset();
        beat("pre0", 1'b0, 1'b1, 1'b0, 1'b0, 2'd0);
        beat("pre1", 1'b0, 1'b1, 1'b0, 1'b0, 2'd0);
        beat("pre2", 1'b0, 1'b1, 1'b0, 1'b0, 2'd0);
        exp_q.push_back(4'b0101);
        beat("f2b0", 1'b1, 1'b0, 1'b0, 1'b0, 2'd1);
        beat("f2b1", 1'b0, 1'b1, 1'b0, 1'b0, 2'd2);
        beat("f2b2", 1'b0, 1'b0, 1'b0, 1'b0, 2'd3);
        beat("f2b3", 1'b0, 1'b1, 1'b1, 1'b0, 2'd0);

        // Early sof at slot 2, then three beats of 1
        beat("eb0", 1'b1, 1'b0, 1'b0, 1'b0, 2'd1);
        beat("eb1", 1'b0, 1'b0, 1'b0, 1'b0, 2'd2);
        exp_q.push_back(4'b1111);
        beat("eb_sof", 1'b1, 1'b1, 1'b0, 1'b1, 2'd1);
        beat("eb3", 1'b0, 1'b1, 1'b0, 1'b0, 2'd2);
        beat("eb4", 1'b0, 1'b1, 1'b0, 1'b0, 2'd3);
        beat("eb5", 1'b0, 1'b1, 1'b1, 1'b0, 2'd0);

        // Back-to-back frames, sof at slot 0 while in sync
        exp_q.push_back(4'b1001);
        beat("bb0", 1'b1, 1'b1, 1'b0, 1'b0, 2'd1);
        beat("bb1", 1'b0, 1'b0, 1'b0, 1'b0, 2'd2);
        beat("bb2", 1'b0, 1'b0, 1'b0, 1'b0, 2'd3);
        beat("bb3", 1'b0, 1'b1, 1'b1, 1'b0, 2'd0);
        exp_q.push_back(4'b0010);
        beat("bb4", 1'b1, 1'b0, 1'b0, 1'b0, 2'd1);
        beat("bb5", 1'b0, 1'b0, 1'b0, 1'b0, 2'd2);
        beat("bb6", 1'b0, 1'b1, 1'b0, 1'b0, 2'd3);
        beat("bb7", 1'b0, 1'b0, 1'b1, 1'b0, 2'd0);

        // Missing sof drops back to hunt; next sof frame accepted
        beat("ms0", 1'b0, 1'b1, 1'b0, 1'b1, 2'd0);
        beat("ms1", 1'b0, 1'b1, 1'b0, 1'b0, 2'd0);
        exp_q.push_back(4'b1101);
        beat("ms2", 1'b1, 1'b1, 1'b0, 1'b0, 2'd1);
        beat("ms3", 1'b0, 1'b1, 1'b0, 1'b0, 2'd2);
        beat("ms4", 1'b0, 1'b0, 1'b0, 1'b0, 2'd3);
        beat("ms5", 1'b0, 1'b1, 1'b1, 1'b0, 2'd0);

        // Stalls of 5 idle cycles between beats
        exp_q.push_back(4'b0110);
        beat("st0", 1'b1, 1'b0, 1'b0, 1'b0, 2'd1);
        idle(5, 2'd1);
        beat("st1", 1'b0, 1'b1, 1'b0, 1'b0, 2'd2);
        idle(5, 2'd2);
        beat("st2", 1'b0, 1'b1, 1'b0, 1'b0, 2'd3);
        idle(5, 2'd3);
        beat("st3", 1'b0, 1'b0, 1'b1, 1'b0, 2'd0);
        idle(5, 2'd0);

        // Reset between beats 2 and 3, then resume only on sof
        beat("rm0", 1'b1, 1'b1, 1'b0, 1'b0, 2'd1);
        beat("rm1", 1'b0, 1'b1, 1'b0, 1'b0, 2'd2);
        do_reset();
        beat("rm2", 1'b0, 1'b1, 1'b0, 1'b0, 2'd0);
        beat("rm3", 1'b0, 1'b1, 1'b0, 1'b0, 2'd0);
        exp_q.push_back(4'b1011);
        beat("rm4", 1'b1, 1'b1, 1'b0, 1'b0, 2'd1);
        beat("rm5", 1'b0, 1'b0, 1'b0, 1'b0, 2'd2);
        beat("rm6", 1'b0, 1'b1, 1'b0, 1'b0, 2'd3);
        beat("rm7", 1'b0, 1'b1, 1'b1, 1'b0, 2'd0);
        idle(2, 2'd0);

        check("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
